// File: rtl/bnn_feature_packer.sv
// bnn_feature_packer: binarizes a byte stream of sensor features against
// programmable per-feature thresholds and packs them into an N_FEAT-bit frame.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        byte-stream handshake
//   in_data, in_cfg, in_last feature/threshold byte, config qualifier, frame end
//   feat_vec/feat_valid/feat_ready  packed frame handshake to the core
//   err_clr, frame_err       sticky framing error and its clear
module bnn_feature_packer #(
  parameter int unsigned N_FEAT    = 16,
  parameter logic [7:0]  THR_RESET = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_cfg,
  input  logic              in_last,
  output logic              in_ready,
  output logic [N_FEAT-1:0] feat_vec,
  output logic              feat_valid,
  input  logic              feat_ready,
  input  logic              err_clr,
  output logic              frame_err
);

  localparam int unsigned IW = $clog2(N_FEAT);
  localparam logic [IW-1:0] LAST = IW'(N_FEAT - 1);

  typedef enum logic {COLLECT, PRESENT} state_t;

  state_t            state, state_next;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     cfg_idx;
  logic [7:0]        thr [N_FEAT];
  logic [N_FEAT-1:0] vec;
  logic              accept_cfg;
  logic              accept_data;
  logic              frame_done;
  logic              err_set;

  assign in_ready   = (state == COLLECT);
  assign feat_valid = (state == PRESENT);
  assign feat_vec   = vec;

  always_comb begin
    accept_cfg  = 1'b0;
    accept_data = 1'b0;
    frame_done  = 1'b0;
    err_set     = 1'b0;
    state_next  = state;
    case (state)
      COLLECT: begin
        accept_cfg  = in_valid && in_cfg;
        accept_data = in_valid && !in_cfg;
        frame_done  = accept_data && (idx == LAST) && in_last;
        // in_last must coincide exactly with the final index; any other pairing is a framing error
        err_set     = accept_data && ((idx == LAST) ^ in_last);
        if (frame_done) begin
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (feat_ready) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      idx       <= '0;
      cfg_idx   <= '0;
      vec       <= '0;
      frame_err <= 1'b0;
      for (int unsigned i = 0; i < N_FEAT; i++) begin
        thr[i] <= THR_RESET;
      end
    end else begin
      state <= state_next;

      if (accept_cfg) begin
        thr[cfg_idx] <= in_data;
        cfg_idx      <= (cfg_idx == LAST) ? '0 : cfg_idx + 1'b1;
      end

      if (accept_data) begin
        vec[idx] <= (in_data >= thr[idx]);
        idx      <= (frame_done || err_set) ? '0 : idx + 1'b1;
      end

      if (err_set) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bnn_feature_packer.sv
module tb_bnn_feature_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_cfg;
  logic        in_last;
  logic        in_ready;
  logic [15:0] feat_vec;
  logic        feat_valid;
  logic        feat_ready;
  logic        err_clr;
  logic        frame_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] sb [$];
  logic [7:0]  thr_m [16];
  int unsigned m_idx;
  int unsigned m_cfg;
  logic [15:0] m_vec;
  logic        m_err;
  logic [7:0]  fd [16];
  logic [15:0] held;

  bnn_feature_packer #(.N_FEAT(16), .THR_RESET(8'h80)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_cfg    (in_cfg),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .feat_vec  (feat_vec),
    .feat_valid(feat_valid),
    .feat_ready(feat_ready),
    .err_clr   (err_clr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) thr_m[i] = 8'h80;
    m_idx = 0;
    m_cfg = 0;
    m_vec = '0;
    m_err = 1'b0;
    sb.delete();
  endtask

  // Drives one beat, waits (bounded) for acceptance, updates the reference model.
  task automatic send_beat(input logic [7:0] d, input logic c, input logic l);
    int unsigned w;
    in_valid = 1'b1;
    in_data  = d;
    in_cfg   = c;
    in_last  = l;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check("ready_timeout", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    if (c) begin
      thr_m[m_cfg] = d;
      m_cfg = (m_cfg == 15) ? 0 : m_cfg + 1;
    end else begin
      m_vec[m_idx] = (d >= thr_m[m_idx]);
      if (m_idx == 15 && l) begin
        sb.push_back(m_vec);
        m_idx = 0;
      end else if (m_idx == 15 || l) begin
        m_err = 1'b1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    #1;
    in_valid = 1'b0;
    in_cfg   = 1'b0;
    in_last  = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 16; i++) send_beat(fd[i], 1'b0, i == 15);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_valid"}, {63'b0, feat_valid}, 64'd1);
    check({tag, "_ready"}, {63'b0, in_ready}, 64'd0);
    check({tag, "_sb"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) check({tag, "_vec"}, {48'b0, feat_vec}, {48'b0, sb.pop_front()});
  endtask

  task automatic release_frame(input string tag);
    feat_ready = 1'b1;
    tick();
    feat_ready = 1'b0;
    check({tag, "_rel_valid"}, {63'b0, feat_valid}, 64'd0);
    check({tag, "_rel_ready"}, {63'b0, in_ready}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vec"}, {48'b0, feat_vec}, 64'd0);
    check({tag, "_valid"}, {63'b0, feat_valid}, 64'd0);
    check({tag, "_ready"}, {63'b0, in_ready}, 64'd1);
    check({tag, "_err"}, {63'b0, frame_err}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_cfg = 1'b0; in_last = 1'b0;
    feat_ready = 1'b0; err_clr = 1'b0;
    model_reset();

    // Reset defaults, all thresholds 0x80
    do_reset();
    check_idle("reset");
    for (int i = 0; i < 15; i++) send_beat(8'h80, 1'b0, 1'b0);
    check("rst_thr_early_valid", {63'b0, feat_valid}, 64'd0);
    send_beat(8'h80, 1'b0, 1'b1);
    check("rst_thr_const", {48'b0, feat_vec}, 64'h0000_0000_0000_FFFF);
    check_frame("rst_thr");
    release_frame("rst_thr");

    // Programmed thresholds 0x10*i
    for (int i = 0; i < 16; i++) send_beat(8'(16 * i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) fd[i] = (i == 0) ? 8'h00 : ((i % 2) ? 8'(16 * i) : 8'(16 * i - 1));
    send_frame();
    check("prog_const", {48'b0, feat_vec}, 64'h0000_0000_0000_AAAB);
    check_frame("prog");

    // Back-pressure with data offered
    held = feat_vec;
    in_valid = 1'b1; in_data = 8'hFF; in_cfg = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_ready", {63'b0, in_ready}, 64'd0);
      check("bp_stable", {48'b0, feat_vec}, {48'b0, held});
    end
    release_frame("bp");
    for (int i = 0; i < 16; i++) fd[i] = 8'($urandom_range(0, 255));
    send_frame();
    check_frame("bp_next");
    release_frame("bp_next");

    // Early in_last on beat 5
    for (int i = 0; i < 5; i++) send_beat(8'hFF, 1'b0, i == 4);
    check("early_err", {63'b0, frame_err}, {63'b0, m_err});
    check("early_novalid", {63'b0, feat_valid}, 64'd0);
    for (int i = 0; i < 16; i++) fd[i] = 8'($urandom_range(0, 255));
    send_frame();
    check_frame("after_early");
    release_frame("after_early");

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 1'b0;
    check("clr_err", {63'b0, frame_err}, 64'd0);

    // Missing in_last on beat 16
    for (int i = 0; i < 16; i++) send_beat(8'hFF, 1'b0, 1'b0);
    check("miss_err", {63'b0, frame_err}, 64'd1);
    check("miss_novalid", {63'b0, feat_valid}, 64'd0);
    check("miss_sb", 64'(sb.size()), 64'd0);

    err_clr = 1'b1;
    tick();
    m_err = 1'b0;
    check("clr_err2", {63'b0, frame_err}, 64'd0);

    // err_clr coincident with a new error: set wins
    send_beat(8'h00, 1'b0, 1'b0);
    err_clr = 1'b1;
    send_beat(8'h00, 1'b0, 1'b1);
    check("set_wins", {63'b0, frame_err}, 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 1'b0;
    check("clr_err3", {63'b0, frame_err}, 64'd0);

    // Interleaved config: cfg_idx moved to 6, threshold 6 rewritten mid-frame
    for (int i = 0; i < 6; i++) send_beat(8'h40, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) send_beat(8'hFF, 1'b1, 1'b0);
      send_beat(8'h90, 1'b0, i == 15);
    end
    check("ilv_const", {48'b0, feat_vec}, 64'h0000_0000_0000_03BF);
    check_frame("ilv");
    release_frame("ilv");

    // Reset mid-frame after a threshold write
    send_beat(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_beat(8'hFF, 1'b0, 1'b0);
    do_reset();
    check_idle("midrst");
    for (int i = 0; i < 16; i++) fd[i] = 8'h7F;
    send_frame();
    check("midrst_const", {48'b0, feat_vec}, 64'd0);
    check_frame("midrst");
    release_frame("midrst");
    check("final_err", {63'b0, frame_err}, {63'b0, m_err});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
